// File: rtl/float2int_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : float2int_pipe_if                                            |
// | Description : Sample-stream bundle for the float-to-integer converter.     |
// |               Carries the float input stream, the counter clear, the       |
// |               integer output stream and the saturation counter.            |
// |                                                                            |
// |   master (producer/consumer side)     slave (float2int_pipe)               |
// |     in_valid   ->  float word valid     in_float  -> {sign, exp, man}      |
// |     clr_count  ->  clear sat_count      out_valid <- out_int/out_sat valid |
// |     out_int    <-  converted sample     out_sat   <- clipped, NaN or Inf   |
// |     sat_count  <-  saturated-sample count                                  |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface float2int_pipe_if #(
  parameter int MAN   = 23,
  parameter int EXP   = 8,
  parameter int OUT_W = 23,
  parameter int CNT_W = 16
) ();

  logic                    in_valid;
  logic [MAN+EXP:0]        in_float;
  logic                    clr_count;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_int;
  logic                    out_sat;
  logic [CNT_W-1:0]        sat_count;

  modport master (
    output in_valid,
    output in_float,
    output clr_count,
    input  out_valid,
    input  out_int,
    input  out_sat,
    input  sat_count
  );

  modport slave (
    input  in_valid,
    input  in_float,
    input  clr_count,
    output out_valid,
    output out_int,
    output out_sat,
    output sat_count
  );

endinterface
`default_nettype wire

// File: rtl/float2int_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : float2int_pipe                                               |
// | Description : Three-stage IEEE-754 float to signed integer converter with  |
// |               saturation and a sticky saturation counter. One sample per   |
// |               cycle, no backpressure, 3-cycle latency.                     |
// |                                                                            |
// |   clk        in   single clock, rising edge                                |
// |   rst_n      in   asynchronous active-low reset                            |
// |   bus        slave modport of float2int_pipe_if:                           |
// |                in_valid/in_float  -> float stream {sign, exp, man}         |
// |                clr_count          -> synchronous clear of sat_count        |
// |                out_valid/out_int  <- integer stream (OUT_W bits, signed)   |
// |                out_sat            <- sample clipped, or NaN/Inf            |
// |                sat_count          <- saturated-sample count (sticky max)   |
// |                                                                            |
// |   Build option: define FLOAT2INT_ROUND_EN for round-to-nearest-even;       |
// |   otherwise the magnitude is truncated toward zero.                        |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module float2int_pipe #(
  parameter int MAN   = 23,   // mantissa width
  parameter int EXP   = 8,    // exponent width
  parameter int OUT_W = 23,   // output width, 2 <= OUT_W <= MAN+1
  parameter int CNT_W = 16    // saturation counter width
) (
  input wire              clk,
  input wire              rst_n,
  float2int_pipe_if.slave bus
);

  localparam int             c_bias = (1 << (EXP - 1)) - 1;
  localparam logic [OUT_W:0] c_half = (OUT_W + 1)'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] c_max = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] c_min = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic [MAN:0]   c_sig_one  = (MAN + 1)'(1);
  localparam logic [MAN:0]   c_sig_ones = {(MAN + 1){1'b1}};

  // --------------------------------------------------------------------------
  // Valid shift register: one bit per stage
  // --------------------------------------------------------------------------
  logic [2:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 3'b000;
    end else begin
      r_vld <= {r_vld[1:0], bus.in_valid};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: unpack and classify
  // --------------------------------------------------------------------------
  logic           w_exp_zero;
  logic           w_exp_ones;
  logic           w_man_zero;

  logic           r1_sign;
  logic [EXP-1:0] r1_exp;
  logic [MAN:0]   r1_sig;     // {hidden, man}
  logic           r1_zero;    // zero or denormal (flushed)
  logic           r1_inf;
  logic           r1_nan;

  assign w_exp_zero = (bus.in_float[MAN+EXP-1:MAN] == '0);
  assign w_exp_ones = (&bus.in_float[MAN+EXP-1:MAN]);
  assign w_man_zero = (bus.in_float[MAN-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sign <= 1'b0;
      r1_exp  <= '0;
      r1_sig  <= '0;
      r1_zero <= 1'b0;
      r1_inf  <= 1'b0;
      r1_nan  <= 1'b0;
    end else if (bus.in_valid) begin
      r1_sign <= bus.in_float[MAN+EXP];
      r1_exp  <= bus.in_float[MAN+EXP-1:MAN];
      r1_sig  <= {~w_exp_zero, bus.in_float[MAN-1:0]};
      r1_zero <= w_exp_zero;
      r1_inf  <= w_exp_ones & w_man_zero;
      r1_nan  <= w_exp_ones & ~w_man_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: align and round
  // --------------------------------------------------------------------------
  logic signed [31:0] w_e;          // unbiased exponent
  logic [31:0]        w_shift;      // right shift that leaves the integer part
  logic               w_in_range;   // integer part fits in OUT_W magnitude bits
  logic               w_big;        // integer part needs more than OUT_W bits
  logic [OUT_W-1:0]   w_mag_trunc;
  logic               w_round_up;
  logic [OUT_W:0]     w_mag_rnd;
  logic               w_ovf;
  logic               w_at_half;

  logic                 r2_sign;
  logic [OUT_W-2:0]     r2_mag;
  logic                 r2_ovf;
  logic                 r2_at_half;
  logic                 r2_inf;
  logic                 r2_nan;

  assign w_e        = $signed({{(32 - EXP){1'b0}}, r1_exp}) - c_bias;
  assign w_shift    = $unsigned(MAN - w_e);
  // Range runs to OUT_W-1 inclusive so that a magnitude of exactly
  // 2^(OUT_W-1) is still visible to stage 3, where the negative case is legal.
  assign w_in_range = !r1_zero && (w_e >= 0) && (w_e <= OUT_W - 1);
  assign w_big      = !r1_zero && (w_e > OUT_W - 1);

  assign w_mag_trunc = w_in_range ? OUT_W'(r1_sig >> w_shift) : '0;

`ifdef FLOAT2INT_ROUND_EN
  logic w_guard;
  logic w_sticky;

  always_comb begin
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (!r1_zero && (w_e == -1)) begin
      // 0.5 <= |x| < 1: the hidden bit itself is the guard bit
      w_guard  = r1_sig[MAN];
      w_sticky = |r1_sig[MAN-1:0];
    end else if (w_in_range && (w_shift != 0)) begin
      w_guard  = |(r1_sig & (c_sig_one << (w_shift - 1)));
      w_sticky = |(r1_sig & ~(c_sig_ones << (w_shift - 1)));
    end
  end

  // Nearest, ties to even
  assign w_round_up = w_guard & (w_sticky | w_mag_trunc[0]);
`else
  assign w_round_up = 1'b0;
`endif

  assign w_mag_rnd = {1'b0, w_mag_trunc} + (OUT_W + 1)'(w_round_up);
  assign w_ovf     = w_big || (w_mag_rnd >= c_half);
  assign w_at_half = !w_big && (w_mag_rnd == c_half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_sign    <= 1'b0;
      r2_mag     <= '0;
      r2_ovf     <= 1'b0;
      r2_at_half <= 1'b0;
      r2_inf     <= 1'b0;
      r2_nan     <= 1'b0;
    end else if (r_vld[0]) begin
      r2_sign    <= r1_sign;
      r2_mag     <= w_mag_rnd[OUT_W-2:0];
      r2_ovf     <= w_ovf;
      r2_at_half <= w_at_half;
      r2_inf     <= r1_inf;
      r2_nan     <= r1_nan;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: apply sign and saturate
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] w_int_nxt;
  logic             w_sat_nxt;

  logic [OUT_W-1:0] r_out_int;
  logic             r_out_sat;

  always_comb begin
    w_int_nxt = '0;
    w_sat_nxt = 1'b0;
    if (r2_nan) begin
      w_int_nxt = '0;
      w_sat_nxt = 1'b1;
    end else if (r2_inf || r2_ovf) begin
      if (r2_sign && r2_at_half && !r2_inf) begin
        // -2^(OUT_W-1) is the one out-of-range magnitude that fits
        w_int_nxt = c_min;
        w_sat_nxt = 1'b0;
      end else begin
        w_int_nxt = r2_sign ? c_min : c_max;
        w_sat_nxt = 1'b1;
      end
    end else begin
      w_int_nxt = r2_sign ? -{1'b0, r2_mag} : {1'b0, r2_mag};
      w_sat_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_int <= '0;
      r_out_sat <= 1'b0;
    end else if (r_vld[1]) begin
      r_out_int <= w_int_nxt;
      r_out_sat <= w_sat_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturation counter: counts registered saturated outputs, sticks at max,
  // clear has priority over increment.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_sat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (bus.clr_count) begin
      r_sat_count <= '0;
    end else if (r_vld[2] && r_out_sat && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign bus.out_valid = r_vld[2];
  assign bus.out_int   = r_out_int;
  assign bus.out_sat   = r_out_sat;
  assign bus.sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_float2int_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_float2int_pipe                                            |
// | Description : Directed self-checking bench for float2int_pipe. Drives a    |
// |               default-width instance and a CNT_W=4 instance.               |
// |               Expected values follow FLOAT2INT_ROUND_EN when defined.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_float2int_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  float2int_pipe_if                bus  ();
  float2int_pipe_if #(.CNT_W(4))   bus4 ();

  float2int_pipe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  float2int_pipe #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

`ifdef FLOAT2INT_ROUND_EN
  localparam bit c_rnd = 1'b1;
`else
  localparam bit c_rnd = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One isolated sample: drive for a cycle, then look 3 cycles later.
  task automatic run1(input logic [31:0] f, input longint exp_i, input logic exp_s,
                      input string tag);
    bus.in_valid = 1'b1;
    bus.in_float = f;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check({tag, "/valid"}, longint'(bus.out_valid), 1);
    check({tag, "/int"},   longint'($signed(bus.out_int)), exp_i);
    check({tag, "/sat"},   longint'(bus.out_sat), longint'(exp_s));
  endtask

  logic [31:0] s_float [6];
  logic        s_vld   [6];
  longint      s_int   [6];

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_float   = '0;
    bus.clr_count  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_float  = '0;
    bus4.clr_count = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst/valid", longint'(bus.out_valid), 0);
    check("rst/int",   longint'($signed(bus.out_int)), 0);
    check("rst/sat",   longint'(bus.out_sat), 0);
    check("rst/cnt",   longint'(bus.sat_count), 0);
    check("rst/cnt4",  longint'(bus4.sat_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- latency of a single 1.0 ----
    bus.in_valid = 1'b1;
    bus.in_float = 32'h3F80_0000;
    tick();
    bus.in_valid = 1'b0;
    check("lat/c1", longint'(bus.out_valid), 0);
    tick();
    check("lat/c2", longint'(bus.out_valid), 0);
    tick();
    check("lat/c3", longint'(bus.out_valid), 1);
    check("lat/int", longint'($signed(bus.out_int)), 1);
    check("lat/sat", longint'(bus.out_sat), 0);
    tick();
    check("lat/c4", longint'(bus.out_valid), 0);

    // ---- rounding ----
    run1(32'h4060_0000, c_rnd ? 4 : 3, 1'b0, "r3p5");
    run1(32'hC020_0000, -2,            1'b0, "rm2p5");
    run1(32'h3F00_0000, 0,             1'b0, "r0p5");
    run1(32'h3F40_0000, c_rnd ? 1 : 0, 1'b0, "r0p75");

    // ---- range limits ----
    run1(32'h4B00_0000, 4194303, 1'b1, "ovf_pos");
    tick();
    check("ovf_pos/cnt", longint'(bus.sat_count), 1);
    run1(32'hCA80_0000, -4194304, 1'b0, "neg_min");
    run1(32'h4A7F_FFFE, 4194303, c_rnd, "near_max");

    // ---- specials ----
    run1(32'h7FC0_0000, 0,        1'b1, "nan");
    run1(32'hFF80_0000, -4194304, 1'b1, "ninf");
    run1(32'h0000_0001, 0,        1'b0, "denorm");
    run1(32'h8000_0000, 0,        1'b0, "negzero");
    tick();
    check("spec/cnt", longint'(bus.sat_count), c_rnd ? 4 : 3);

    // ---- streaming with a gap; output holds its value across the gap ----
    s_float = '{32'h3F80_0000, 32'h4000_0000, 32'h0000_0000,
                32'hC040_0000, 32'h40E0_0000, 32'h4120_0000};
    s_vld   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    s_int   = '{1, 2, 2, -3, 7, 10};
    for (int t = 0; t < 9; t++) begin
      if (t >= 3) begin
        check($sformatf("strm%0d/valid", t), longint'(bus.out_valid), longint'(s_vld[t-3]));
        check($sformatf("strm%0d/int", t), longint'($signed(bus.out_int)), s_int[t-3]);
      end else begin
        check($sformatf("strm%0d/valid", t), longint'(bus.out_valid), 0);
      end
      bus.in_valid = (t < 6) ? s_vld[t] : 1'b0;
      bus.in_float = (t < 6) ? s_float[t] : 32'h0;
      tick();
    end

    // ---- asynchronous reset mid-stream ----
    bus.in_valid = 1'b1;
    bus.in_float = 32'h40A0_0000;   // 5.0
    tick(); tick(); tick(); tick();
    check("mid/valid", longint'(bus.out_valid), 1);
    check("mid/int",   longint'($signed(bus.out_int)), 5);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst/valid", longint'(bus.out_valid), 0);
    check("arst/int",   longint'($signed(bus.out_int)), 0);
    check("arst/cnt",   longint'(bus.sat_count), 0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      check($sformatf("stale%0d", t), longint'(bus.out_valid), 0);
      tick();
    end
    run1(32'h40E0_0000, 7, 1'b0, "post_rst");

    // ---- CNT_W=4: counter sticks at 15 ----
    for (int t = 0; t < 26; t++) begin
      if (t == 10) check("cnt4/mid", longint'(bus4.sat_count), 7);
      bus4.in_valid = (t < 20);
      bus4.in_float = 32'h4B00_0000;
      tick();
    end
    check("cnt4/stick", longint'(bus4.sat_count), 15);
    bus4.clr_count = 1'b1;
    tick();
    bus4.clr_count = 1'b0;
    check("cnt4/clr", longint'(bus4.sat_count), 0);

    // three saturating samples; clear lands with the third output
    for (int t = 0; t < 5; t++) begin
      bus4.in_valid = (t < 3);
      tick();
    end
    check("cnt4/two",   longint'(bus4.sat_count), 2);
    check("cnt4/osat",  longint'(bus4.out_valid & bus4.out_sat), 1);
    bus4.clr_count = 1'b1;
    tick();
    bus4.clr_count = 1'b0;
    check("cnt4/clrwin", longint'(bus4.sat_count), 0);
    tick();
    check("cnt4/after", longint'(bus4.sat_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float2int_pipe.md
# float2int_pipe

Pipelined IEEE-754 single-precision to signed-integer converter with saturation and a sticky saturation counter. Sits directly downstream of the floating-point IIR stage and consumes its `y_float` output. Returns filtered samples to the fixed-point domain at the same width as the IIR's integer input, for DAC/output framing. Fully pipelined, with one result per cycle and no backpressure.

## Interface
Parameters:
- `MAN`, default 23: mantissa width of the input float.
- `EXP`, default 8: exponent width. The bias is 2^(EXP-1)-1.
- `OUT_W`, default 23: output integer width. Legal range is 2 ≤ OUT_W ≤ MAN+1.
- `CNT_W`, default 16: width of the saturation counter.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: `in_float` is valid this cycle. Tie to 1 for a free-running IIR.
- `in_float`, in, MAN+EXP+1: IEEE-754 word laid out as {sign, exp, man}.
- `clr_count`, in, 1: synchronous clear of `sat_count`.
- `out_valid`, out, 1: `out_int` and `out_sat` are valid.
- `out_int`, out, OUT_W, signed: converted sample.
- `out_sat`, out, 1: this sample was clipped, or was NaN/Inf.
- `sat_count`, out, CNT_W: number of saturated samples. Saturates at all-ones.

## Operation
Stage 1 (unpack/classify) registers the following:
- sign, biased exp, and {hidden, man}. The hidden bit is 1 unless exp==0.
- Class flags:
  - zero/denormal: exp==0. Denormals are flushed to zero.
  - inf: exp all-ones and man==0.
  - nan: exp all-ones and man≠0.

Stage 2 (align/round) works on the unbiased exponent e = exp − bias:
- e < −1: magnitude is 0 for any rounding mode.
- 0 ≤ e < OUT_W−1: magnitude = {1,man} >> (MAN−e). The guard bit and sticky OR of the shifted-out bits are kept for rounding.
- e == −1: magnitude is 0. The guard bit is the hidden bit, so rounding applies.
- e ≥ OUT_W−1: overflow flag set.
- Rounding per Configuration. A rounding carry to 2^(OUT_W−1) sets the overflow flag.

Stage 3 (sign/saturate) registers the outputs:
- Positive overflow or +Inf: out_int = 2^(OUT_W−1)−1, out_sat=1.
- Negative overflow or −Inf: out_int = −2^(OUT_W−1), out_sat=1.
- Exception: a negative input whose magnitude is exactly 2^(OUT_W−1) is representable. It gives out_sat=0.
- NaN: out_int=0, out_sat=1.
- Otherwise out_int = sign ? −mag : mag, out_sat=0. −0.0 gives 0.

Valid pipeline:
- `in_valid` travels down a 3-bit valid shift register alongside the data.
- Data registers update only when their stage valid is set. Outputs hold their last value while out_valid=0.

sat_count:
- Increments on out_valid & out_sat, and holds at 2^CNT_W−1.
- `clr_count` sets it to 0 on the next edge.
- If clr_count and an increment fall in the same cycle, the clear wins and the result is 0.

## Timing
- Latency: in_valid at edge N gives out_valid at edge N+3. Throughput is 1 sample/cycle.
- Gaps in in_valid appear unchanged at the output. Sample order is preserved.
- Reset (rst_n=0) takes effect immediately, regardless of clk, with no clock edge needed:
  - out_valid=0, out_int=0, out_sat=0, sat_count=0.
  - All stage valids and data registers are cleared.
- Reset mid-stream discards the in-flight samples. The first sample after release appears 3 cycles after its in_valid.
- in_valid sampled on the first edge after rst_n rises is accepted.

## Configuration
- `FLOAT2INT_ROUND_EN` defined: round to nearest, ties to even, using guard and sticky bits. The e == −1 case rounds to ±1, except exactly ±0.5, which gives 0.
- Not defined: truncate toward zero. Guard and sticky bits are ignored, and a rounding carry cannot occur.

## Test plan
1. Reset then 0x3F800000 (1.0) with in_valid for one cycle → out_valid high exactly 3 cycles later, out_int=1, out_sat=0.
2. Rounding, with ROUND_EN / without:
   - 0x40600000 (3.5) → 4 / 3.
   - 0xC0200000 (−2.5) → −2 / −2.
   - 0x3F000000 (0.5) → 0 / 0.
   - 0x3F400000 (0.75) → 1 / 0.
3. Range limits, all with default widths:
   - 0x4B000000 (8388608) → 4194303, out_sat=1, sat_count=1.
   - 0xCA800000 (−4194304) → −4194304, out_sat=0.
   - 0x4A7FFFFE (4194303.5) → 4194303 with out_sat=1 under ROUND_EN; 4194303 with out_sat=0 without.
4. Specials:
   - 0x7FC00000 (NaN) → 0, out_sat=1.
   - 0xFF800000 (−Inf) → −4194304, out_sat=1.
   - 0x00000001 (denormal) → 0, out_sat=0.
   - 0x80000000 (−0.0) → 0, out_sat=0.
5. Streaming: 5 samples (1.0, 2.0, gap, −3.0, 7.0, 10.0) → identical valid pattern delayed by 3 cycles, with values 1, 2, −3, 7, 10. Drop rst_n asynchronously mid-stream → out_valid=0 and out_int=0 immediately. No stale samples appear after release.
6. With CNT_W=4, send 20 consecutive overflow samples → sat_count stops at 15. Assert clr_count in the same cycle as a saturating output → sat_count=0 on the next edge.
